// File: rtl/decryption_rx.sv
// decryption_rx: receive-side FIFO + XOR/inverse-permutation decrypt with a valid/ready output.
// Ports: clock/rst (async active-low); en gates push and pop; din/in_v ciphertext pulse in;
// dout/out_v/out_ready plaintext handshake out; ovf sticky overflow; fifo_cnt occupancy.
// Optional DECRYPT_DROP_CNT_EN adds drop_cnt, a saturating count of overflow drops.
module decryption_rx #(
   parameter int N = 8,
   parameter int DEPTH = 4,
   parameter logic [N-1:0] K1 = 8'b0011_1110,
   parameter logic [N-1:0] K2 = 8'b0100_1001,
   parameter logic [N-1:0] K3 = 8'b0111_1110
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     en,
   input  logic [N-1:0]             din,
   input  logic                     in_v,
   output logic [N-1:0]             dout,
   output logic                     out_v,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
`ifdef DECRYPT_DROP_CNT_EN
   output logic [7:0]               drop_cnt,
   output logic                     ovf
`else
   output logic                     ovf
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [N-1:0] K = K1 ^ K2 ^ K3;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   logic [N-1:0]  mem_q [DEPTH];
   logic [N-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  dout_q, dout_d, p;
   logic          out_v_q, out_v_d, ovf_q, ovf_d;
   logic          free, pop, push, drop;
   always_comb begin
      free     = !out_v_q || out_ready;
      pop      = en && free && (cnt_q != '0);
      // a full FIFO still accepts when the same edge pops its head
      push     = en && in_v && (cnt_q != FULL || pop);
      drop     = en && in_v && !push;
      p        = mem_q[rd_ptr_q] ^ K;
      mem_d    = mem_q;
      if (push) mem_d[wr_ptr_q] = din;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      dout_d   = pop ? {p[3], p[4], p[6], p[2], p[1], p[5], p[0], p[7]} : dout_q;
      // a completed handshake clears out_v even when en=0
      out_v_d  = pop || (out_v_q && !free);
      ovf_d    = ovf_q || drop;
   end
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         out_v_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         out_v_q  <= out_v_d;
         ovf_q    <= ovf_d;
      end
   end
`ifdef DECRYPT_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;
   always_comb begin
      drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
   end
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) drop_cnt_q <= '0;
      else drop_cnt_q <= drop_cnt_d;
   end
   assign drop_cnt = drop_cnt_q;
`endif
   assign dout     = dout_q;
   assign out_v    = out_v_q;
   assign ovf      = ovf_q;
   assign fifo_cnt = cnt_q;
endmodule

// File: tb/tb_decryption_rx.sv
// tb_decryption_rx: randomized + directed scoreboard bench for decryption_rx.
module tb_decryption_rx;
   localparam int DEPTH = 4;
   logic clock = 1'b0, rst = 1'b0, en = 1'b0, in_v = 1'b0, out_ready = 1'b0;
   logic [7:0] din = '0;
   logic [7:0] dout;
   logic out_v, ovf;
   logic [2:0] fifo_cnt;
`ifdef DECRYPT_DROP_CNT_EN
   logic [7:0] drop_cnt;
   int m_drops = 0;
`endif
   int n_chk = 0, n_pass = 0;
   logic [7:0] exp_q[$];
   int  m_cnt = 0;
   bit  m_out = 0, m_ovf = 0;
   bit  last_v = 0, last_hs = 0;
   logic [7:0] last_dout = '0;

   decryption_rx #(.DEPTH(DEPTH)) dut (
      .clock(clock), .rst(rst), .en(en), .din(din), .in_v(in_v),
      .dout(dout), .out_v(out_v), .out_ready(out_ready), .fifo_cnt(fifo_cnt),
`ifdef DECRYPT_DROP_CNT_EN
      .drop_cnt(drop_cnt),
`endif
      .ovf(ovf)
   );

   always #5 clock = ~clock;

   task automatic check(input bit ok, input string name, input int act, input int req);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
   endtask

   // plaintext bit i (MSB first) is taken from p[src[i]], p = c ^ K1 ^ K2 ^ K3
   function automatic logic [7:0] dec(input logic [7:0] c);
      int src[8] = '{3, 4, 6, 2, 1, 5, 0, 7};
      logic [7:0] p = c ^ 8'h3E ^ 8'h49 ^ 8'h7E;
      logic [7:0] r = '0;
      for (int i = 0; i < 8; i++) r[7-i] = p[src[i]];
      return r;
   endfunction

   // drive inputs, advance one edge, and update the occupancy-level model
   task automatic step(input bit e, input bit iv, input bit rdy, input logic [7:0] d);
      bit free, pop, acc;
      en = e; in_v = iv; out_ready = rdy; din = d;
      @(posedge clock);
      if (rst) begin
         free = !m_out || out_ready;
         pop  = en && free && m_cnt > 0;
         acc  = en && in_v && (m_cnt < DEPTH || pop);
         if (acc) exp_q.push_back(dec(din));
         if (en && in_v && !acc) begin
            m_ovf = 1;
`ifdef DECRYPT_DROP_CNT_EN
            if (m_drops < 255) m_drops++;
`endif
         end
         m_cnt = m_cnt + int'(acc) - int'(pop);
         m_out = pop ? 1'b1 : (free ? 1'b0 : m_out);
      end
      #1;
   endtask

   task automatic check_reset();
      check(out_v == 1'b0, "rst_out_v", out_v, 0);
      check(dout == 8'h00, "rst_dout", dout, 0);
      check(fifo_cnt == 3'd0, "rst_fifo_cnt", fifo_cnt, 0);
      check(ovf == 1'b0, "rst_ovf", ovf, 0);
   endtask

   task automatic drain_check(input string name);
      for (int i = 0; i < 8; i++) step(1, 0, 1, 8'h00);
      check(exp_q.size() == 0, name, exp_q.size(), 0);
   endtask

   // monitor: compares each new output against the scoreboard head, and state against the model
   always @(negedge clock) begin
      logic [7:0] e;
      if (!rst) begin
         last_v = 0; last_hs = 0;
      end else begin
         if (out_v && (!last_v || last_hs)) begin
            if (exp_q.size() == 0) check(0, "dout_unexpected", dout, 0);
            else begin
               e = exp_q.pop_front();
               check(dout == e, "dout", dout, e);
            end
         end else if (out_v) check(dout == last_dout, "dout_hold", dout, last_dout);
         check(out_v == m_out, "out_v", out_v, m_out);
         check(int'(fifo_cnt) == m_cnt, "fifo_cnt", fifo_cnt, m_cnt);
         check(ovf == m_ovf, "ovf", ovf, m_ovf);
`ifdef DECRYPT_DROP_CNT_EN
         check(int'(drop_cnt) == m_drops, "drop_cnt", drop_cnt, m_drops);
`endif
         last_v = out_v; last_hs = out_v && out_ready; last_dout = dout;
      end
   end

   initial begin
      step(0, 0, 0, 8'h00);
      check_reset();
      rst = 1'b1;
      step(0, 0, 1, 8'h00);
      // single byte: E1 decrypts to A5
      step(1, 1, 1, 8'hE1);
      for (int i = 0; i < 3; i++) step(1, 0, 1, 8'h00);
      // back-to-back bytes
      step(1, 1, 1, 8'h09);
      step(1, 1, 1, 8'hF6);
      step(1, 1, 1, 8'hE1);
      drain_check("drain_b2b");
      // overflow: 1 in output register, 4 in FIFO, 6th dropped
      for (int i = 0; i < 6; i++) step(1, 1, 0, 8'($urandom));
      check(fifo_cnt == 3'd4, "full_cnt", fifo_cnt, 4);
      check(ovf == 1'b1, "ovf_set", ovf, 1);
      drain_check("drain_five");
      // full FIFO with simultaneous push and pop
      for (int i = 0; i < 5; i++) step(1, 1, 0, 8'($urandom));
      step(1, 1, 1, 8'($urandom));
      check(fifo_cnt == 3'd4, "full_push_pop_cnt", fifo_cnt, 4);
      drain_check("drain_full");
      // en=0 lets the pending handshake finish but stops popping
      for (int i = 0; i < 3; i++) step(1, 1, 0, 8'($urandom));
      step(0, 0, 1, 8'h00);
      step(0, 1, 1, 8'($urandom));
      step(0, 0, 1, 8'h00);
      check(fifo_cnt == 3'd2, "en0_cnt", fifo_cnt, 2);
      check(out_v == 1'b0, "en0_out_v", out_v, 0);
      drain_check("drain_en");
      // asynchronous reset mid-stream with 3 bytes buffered
      for (int i = 0; i < 4; i++) step(1, 1, 0, 8'($urandom));
      check(fifo_cnt == 3'd3, "pre_rst_cnt", fifo_cnt, 3);
      #2 rst = 1'b0;
      exp_q.delete(); m_cnt = 0; m_out = 0; m_ovf = 0;
`ifdef DECRYPT_DROP_CNT_EN
      m_drops = 0;
`endif
      #1 check_reset();
      #4 rst = 1'b1;
      en = 1'b0; in_v = 1'b0;
      step(1, 1, 1, 8'h09);
      step(1, 0, 1, 8'h00);
      check(dout == 8'h00 && out_v, "post_rst_dout", dout, 0);
      // randomized traffic
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 8'($urandom));
      drain_check("drain_random");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
